// File: rtl/ram_access_arbiter.sv
// Two-requester arbiter for a byte-enabled simple dual-port RAM: funct3 lane/extend handling, 3-cycle accesses.
// Optional macro ARB_ROUND_ROBIN_EN enables a last-grant pointer; otherwise m0 has strict priority.
module ram_access_arbiter #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_m0_req,
  input  logic              i_m0_we,
  input  logic [ADDR_W+1:0] i_m0_addr,
  input  logic [2:0]        i_m0_size,
  input  logic [31:0]       i_m0_wdata,
  input  logic              i_m1_req,
  input  logic              i_m1_we,
  input  logic [ADDR_W+1:0] i_m1_addr,
  input  logic [2:0]        i_m1_size,
  input  logic [31:0]       i_m1_wdata,
  output logic              o_m0_gnt,
  output logic              o_m0_rvalid,
  output logic [31:0]       o_m0_rdata,
  output logic              o_m0_err,
  output logic              o_m1_gnt,
  output logic              o_m1_rvalid,
  output logic [31:0]       o_m1_rdata,
  output logic              o_m1_err,
  output logic              o_ram_we,
  output logic [3:0]        o_ram_be,
  output logic [ADDR_W-1:0] o_ram_waddr,
  output logic [ADDR_W-1:0] o_ram_raddr,
  output logic [31:0]       o_ram_wdata,
  input  logic [31:0]       i_ram_q
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t            r_state, w_next;
  logic              r_sel;          // 0 = m0 owns the access, 1 = m1
  logic              r_we;
  logic [ADDR_W+1:0] r_addr;
  logic [2:0]        r_size;
  logic [31:0]       r_wdata;

  logic              w_any_req, w_pick_m1, w_err;
  logic [3:0]        w_be;
  logic [31:0]       w_lane_wdata, w_shift, w_ext, w_rdata;

  assign w_any_req = i_m0_req | i_m1_req;

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last;  // 1 = m1 was granted last; resets to 1 so m0 wins first

  assign w_pick_m1 = i_m1_req & (~i_m0_req | ~r_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                r_last <= 1'b1;
    else if (r_state == S_IDLE && w_any_req)   r_last <= w_pick_m1;
  end
`else
  assign w_pick_m1 = i_m1_req & ~i_m0_req;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // NOTE: the latched request fields are reset too; they are few and it keeps outputs deterministic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_size  <= '0;
      r_wdata <= '0;
    end else if (r_state == S_IDLE && w_any_req) begin
      r_sel   <= w_pick_m1;
      r_we    <= w_pick_m1 ? i_m1_we    : i_m0_we;
      r_addr  <= w_pick_m1 ? i_m1_addr  : i_m0_addr;
      r_size  <= w_pick_m1 ? i_m1_size  : i_m0_size;
      r_wdata <= w_pick_m1 ? i_m1_wdata : i_m0_wdata;
    end
  end

  // NOTE: every always_comb assigns defaults first so no path can infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_any_req) w_next = S_ACCESS;
      S_ACCESS: w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_err = 1'b0;
    case (r_size)
      3'b000, 3'b100: w_err = 1'b0;
      3'b001, 3'b101: w_err = r_addr[0];
      3'b010:         w_err = (r_addr[1:0] != 2'b00);
      default:        w_err = 1'b1;
    endcase
  end

  always_comb begin
    w_be         = 4'b1111;
    w_lane_wdata = r_wdata;
    case (r_size[1:0])
      2'b00: begin
        w_be         = 4'b0001 << r_addr[1:0];
        w_lane_wdata = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_be         = r_addr[1] ? 4'b1100 : 4'b0011;
        w_lane_wdata = {2{r_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign w_shift = i_ram_q >> {r_addr[1:0], 3'b000};

  always_comb begin
    w_ext = '0;
    case (r_size)
      3'b000:  w_ext = {{24{w_shift[7]}}, w_shift[7:0]};
      3'b001:  w_ext = {{16{w_shift[15]}}, w_shift[15:0]};
      3'b010:  w_ext = w_shift;
      3'b100:  w_ext = {24'h0, w_shift[7:0]};
      3'b101:  w_ext = {16'h0, w_shift[15:0]};
      default: w_ext = '0;
    endcase
  end

  assign w_rdata = (w_err || r_we) ? 32'h0 : w_ext;

  always_comb begin
    o_m0_gnt    = 1'b0;
    o_m1_gnt    = 1'b0;
    o_m0_rvalid = 1'b0;
    o_m1_rvalid = 1'b0;
    o_m0_rdata  = '0;
    o_m1_rdata  = '0;
    o_m0_err    = 1'b0;
    o_m1_err    = 1'b0;
    o_ram_we    = 1'b0;
    o_ram_be    = '0;
    o_ram_waddr = '0;
    o_ram_raddr = '0;
    o_ram_wdata = '0;
    case (r_state)
      S_ACCESS: begin
        o_m0_gnt = ~r_sel;
        o_m1_gnt = r_sel;
        // Erroneous accesses consume the slot but leave the RAM untouched.
        if (!w_err) begin
          if (r_we) begin
            o_ram_we    = 1'b1;
            o_ram_be    = w_be;
            o_ram_waddr = r_addr[ADDR_W+1:2];
            o_ram_wdata = w_lane_wdata;
          end else begin
            o_ram_raddr = r_addr[ADDR_W+1:2];
          end
        end
      end
      S_RESP: begin
        if (r_sel) begin
          o_m1_rvalid = 1'b1;
          o_m1_err    = w_err;
          o_m1_rdata  = w_rdata;
        end else begin
          o_m0_rvalid = 1'b1;
          o_m0_err    = w_err;
          o_m0_rdata  = w_rdata;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Directed bench for ram_access_arbiter with a behavioural byte-enabled RAM behind it.
module tb_ram_access_arbiter;
  localparam int ADDR_W = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        m0_req, m0_we, m1_req, m1_we;
  logic [9:0]  m0_addr, m1_addr;
  logic [2:0]  m0_size, m1_size;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        ram_we;
  logic [3:0]  ram_be;
  logic [7:0]  ram_waddr, ram_raddr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_q = 32'h0;
  logic [31:0] mem [256] = '{default: 32'h0};

  int n_cmp = 0;
  int n_err = 0;

  ram_access_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_m0_req(m0_req), .i_m0_we(m0_we), .i_m0_addr(m0_addr), .i_m0_size(m0_size), .i_m0_wdata(m0_wdata),
    .i_m1_req(m1_req), .i_m1_we(m1_we), .i_m1_addr(m1_addr), .i_m1_size(m1_size), .i_m1_wdata(m1_wdata),
    .o_m0_gnt(m0_gnt), .o_m0_rvalid(m0_rvalid), .o_m0_rdata(m0_rdata), .o_m0_err(m0_err),
    .o_m1_gnt(m1_gnt), .o_m1_rvalid(m1_rvalid), .o_m1_rdata(m1_rdata), .o_m1_err(m1_err),
    .o_ram_we(ram_we), .o_ram_be(ram_be), .o_ram_waddr(ram_waddr), .o_ram_raddr(ram_raddr),
    .o_ram_wdata(ram_wdata), .i_ram_q(ram_q)
  );

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (ram_we && ram_be[i]) mem[ram_waddr][8*i +: 8] <= ram_wdata[8*i +: 8];
    ram_q <= mem[ram_raddr];
  end

  wire [122:0] all_outs = {m0_gnt, m0_rvalid, m0_rdata, m0_err, m1_gnt, m1_rvalid, m1_rdata, m1_err,
                           ram_we, ram_be, ram_waddr, ram_raddr, ram_wdata};

  // Issues one access from master m and checks the ACCESS and RESP cycles; enters and leaves at a negedge.
  task automatic run_access(input int m, input logic we, input logic [9:0] addr, input logic [2:0] size,
                            input logic [31:0] wdata, input logic exp_err, input logic [3:0] exp_be,
                            input logic [31:0] exp_ram_wdata, input logic [31:0] exp_rdata, input string name);
    int   waited = 0;
    logic gnt, other_gnt, rv, other_rv, er;
    logic [31:0] rd;
    if (m == 0) begin m0_we = we; m0_addr = addr; m0_size = size; m0_wdata = wdata; m0_req = 1'b1; end
    else        begin m1_we = we; m1_addr = addr; m1_size = size; m1_wdata = wdata; m1_req = 1'b1; end
    do begin
      @(negedge clk);
      waited++;
      gnt = (m == 0) ? m0_gnt : m1_gnt;
    end while (!gnt && waited < 6);
    m0_req = 1'b0;
    m1_req = 1'b0;
    n_cmp++;
    if (waited !== 1) begin
      $display("FAIL %s gnt_latency: got %0d cycles, want 1", name, waited);
      n_err++;
      return;
    end
    other_gnt = (m == 0) ? m1_gnt : m0_gnt;
    n_cmp++;
    if (other_gnt !== 1'b0) begin $display("FAIL %s other_gnt: got %b, want 0", name, other_gnt); n_err++; end
    n_cmp++;
    if (ram_we !== (we && !exp_err)) begin
      $display("FAIL %s ram_we: got %b, want %b", name, ram_we, we && !exp_err); n_err++;
    end
    if (we && !exp_err) begin
      n_cmp++;
      if ({ram_be, ram_waddr, ram_wdata} !== {exp_be, addr[9:2], exp_ram_wdata}) begin
        $display("FAIL %s ram_write: got be=%b waddr=%h wdata=%h, want be=%b waddr=%h wdata=%h",
                 name, ram_be, ram_waddr, ram_wdata, exp_be, addr[9:2], exp_ram_wdata);
        n_err++;
      end
    end else begin
      n_cmp++;
      if (ram_raddr !== (exp_err ? 8'h00 : addr[9:2])) begin
        $display("FAIL %s ram_raddr: got %h, want %h", name, ram_raddr, exp_err ? 8'h00 : addr[9:2]);
        n_err++;
      end
    end
    @(negedge clk);
    rv       = (m == 0) ? m0_rvalid : m1_rvalid;
    other_rv = (m == 0) ? m1_rvalid : m0_rvalid;
    er       = (m == 0) ? m0_err    : m1_err;
    rd       = (m == 0) ? m0_rdata  : m1_rdata;
    n_cmp++;
    if ({rv, other_rv, er, rd, ram_we} !== {1'b1, 1'b0, exp_err, exp_rdata, 1'b0}) begin
      $display("FAIL %s resp: got rvalid=%b other=%b err=%b rdata=%h ram_we=%b, want 1 0 %b %h 0",
               name, rv, other_rv, er, rd, ram_we, exp_err, exp_rdata);
      n_err++;
    end
    @(negedge clk);
    n_cmp++;
    if (all_outs !== '0) begin $display("FAIL %s idle_after: outputs %h, want 0", name, all_outs); n_err++; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_size = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_size = '0; m1_wdata = '0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (all_outs !== '0) begin $display("FAIL reset_outs: got %h, want 0", all_outs); n_err++; end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (all_outs !== '0) begin $display("FAIL idle_no_req cycle %0d: got %h, want 0", i, all_outs); n_err++; end
    end
  endtask

  task automatic test_word();
    run_access(0, 1'b1, 10'h004, 3'b010, 32'hDEADBEEF, 1'b0, 4'b1111, 32'hDEADBEEF, 32'h0, "sw_04");
    run_access(0, 1'b0, 10'h004, 3'b010, 32'h0, 1'b0, 4'b0000, 32'h0, 32'hDEADBEEF, "lw_04");
    run_access(1, 1'b1, 10'h3FC, 3'b010, 32'h01234567, 1'b0, 4'b1111, 32'h01234567, 32'h0, "sw_top");
    run_access(1, 1'b0, 10'h3FC, 3'b010, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h01234567, "lw_top");
  endtask

  task automatic test_byte_half();
    run_access(1, 1'b1, 10'h007, 3'b000, 32'h000000A5, 1'b0, 4'b1000, 32'hA5A5A5A5, 32'h0, "sb_07");
    run_access(1, 1'b0, 10'h007, 3'b000, 32'h0, 1'b0, 4'b0000, 32'h0, 32'hFFFFFFA5, "lb_07");
    run_access(1, 1'b0, 10'h007, 3'b100, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h000000A5, "lbu_07");
    run_access(0, 1'b0, 10'h006, 3'b001, 32'h0, 1'b0, 4'b0000, 32'h0, 32'hFFFFA5AD, "lh_06");
    run_access(0, 1'b0, 10'h006, 3'b101, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0000A5AD, "lhu_06");
    run_access(0, 1'b1, 10'h002, 3'b001, 32'hFFFF1234, 1'b0, 4'b1100, 32'h12341234, 32'h0, "sh_02");
    run_access(0, 1'b0, 10'h000, 3'b010, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h12340000, "lw_00");
  endtask

  task automatic test_error();
    run_access(0, 1'b0, 10'h003, 3'b001, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0, "lh_03_err");
    run_access(0, 1'b0, 10'h000, 3'b011, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0, "size011_err");
    run_access(1, 1'b1, 10'h006, 3'b010, 32'hFFFFFFFF, 1'b1, 4'b0000, 32'h0, 32'h0, "sw_06_err");
    run_access(0, 1'b0, 10'h004, 3'b010, 32'h0, 1'b0, 4'b0000, 32'h0, 32'hA5ADBEEF, "lw_04_after_err");
  endtask

  task automatic test_arbitration();
    int cnt0 = 4, cnt1 = 4, k = 0, cycles = 0, since = 0;
    int order [8];
    int exp_order [8];
`ifdef ARB_ROUND_ROBIN_EN
    exp_order = '{0, 1, 0, 1, 0, 1, 0, 1};
`else
    exp_order = '{0, 0, 0, 0, 1, 1, 1, 1};
`endif
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m0_we = 0; m0_addr = 10'h004; m0_size = 3'b010;
    m1_we = 0; m1_addr = 10'h004; m1_size = 3'b010;
    m0_req = 1'b1;
    m1_req = 1'b1;
    while ((cnt0 > 0 || cnt1 > 0) && cycles < 60) begin
      @(negedge clk);
      cycles++;
      since++;
      if (m0_gnt && m1_gnt) begin
        n_cmp++; n_err++;
        $display("FAIL arb_both_gnt: got both grants, want one");
      end
      if ((m0_gnt || m1_gnt) && k < 8) begin
        if (k > 0) begin
          n_cmp++;
          if (since !== 3) begin $display("FAIL arb_spacing %0d: got %0d cycles, want 3", k, since); n_err++; end
        end
        order[k] = m1_gnt ? 1 : 0;
        if (m1_gnt) cnt1--; else cnt0--;
        k++;
        since = 0;
      end
      m0_req = (cnt0 > 0);
      m1_req = (cnt1 > 0);
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
    n_cmp++;
    if (k !== 8) begin $display("FAIL arb_count: got %0d grants, want 8", k); n_err++; end
    for (int i = 0; i < 8 && i < k; i++) begin
      n_cmp++;
      if (order[i] !== exp_order[i]) begin
        $display("FAIL arb_order[%0d]: got m%0d, want m%0d", i, order[i], exp_order[i]); n_err++;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    m0_we = 1; m0_addr = 10'h008; m0_size = 3'b010; m0_wdata = 32'hCAFEF00D; m0_req = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({m0_gnt, ram_we} !== 2'b11) begin $display("FAIL abort_access: got gnt/we=%b%b, want 11", m0_gnt, ram_we); n_err++; end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (all_outs !== '0) begin $display("FAIL abort_outs: got %h, want 0", all_outs); n_err++; end
    m0_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({m0_rvalid, m1_rvalid, ram_we} !== 3'b000) begin
        $display("FAIL abort_no_rvalid %0d: got %b%b%b, want 000", i, m0_rvalid, m1_rvalid, ram_we); n_err++;
      end
    end
    run_access(0, 1'b0, 10'h008, 3'b010, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h00000000, "lw_08_unwritten");
    run_access(0, 1'b1, 10'h008, 3'b010, 32'hCAFEF00D, 1'b0, 4'b1111, 32'hCAFEF00D, 32'h0, "sw_08_reissue");
    run_access(0, 1'b0, 10'h008, 3'b010, 32'h0, 1'b0, 4'b0000, 32'h0, 32'hCAFEF00D, "lw_08");
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte_half();
    test_error();
    test_arbitration();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
